// File: rtl/output_requant_if.sv
// ---------------------------------------------------------------------------
// output_requant_if
//   Output stream of the requantizer towards the output memory writer.
//   One beat carries one packed row of SYS_COLS signed O_BITWIDTH words.
//
//   m_valid  head row is valid                       (master -> slave)
//   m_ready  slave accepts the head row              (slave  -> master)
//   m_data   packed row, column c at [c*O_BITWIDTH +: O_BITWIDTH]
//   m_strb   per-column valid
//   m_last   head row is the last row of the tile
// ---------------------------------------------------------------------------
interface output_requant_if #(
  parameter int SYS_COLS   = 4,
  parameter int O_BITWIDTH = 8
);
  logic                             m_valid;
  logic                             m_ready;
  logic [SYS_COLS*O_BITWIDTH-1:0]   m_data;
  logic [SYS_COLS-1:0]              m_strb;
  logic                             m_last;

  modport master (
    output m_valid,
    output m_data,
    output m_strb,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_strb,
    input  m_last,
    output m_ready
  );
endinterface

// File: rtl/output_requant.sv
// ---------------------------------------------------------------------------
// output_requant
//   Requantizes rows of accumulator partial sums and buffers them for the
//   output memory writer.
//     S1 : rounding arithmetic right shift (computed one bit wider so the
//          rounding add cannot wrap)
//     S2 : optional ReLU, then signed saturation to O_BITWIDTH
//     FIFO (first-word-fall-through with a registered head) drained over a
//          valid/ready handshake; the last row of each tile is tagged.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-low reset
//   cfg_load     pulse: latch cfg_shift/cfg_relu/cfg_rows, clear row counter
//   cfg_shift    right-shift amount 0..31
//   cfg_relu     1 = clamp negative results to 0
//   cfg_rows     rows per tile (>= 1)
//   in_valid     per-column valid of the incoming row
//   in_data      signed sums, column c at [c*P_BITWIDTH +: P_BITWIDTH]
//   almost_full  registered, FIFO occupancy >= FIFO_DEPTH-2
//   overflow     sticky, a row was dropped because the FIFO was full
//   m            output stream (master modport)
// ---------------------------------------------------------------------------
module output_requant #(
  parameter int SYS_COLS   = 4,
  parameter int P_BITWIDTH = 32,
  parameter int O_BITWIDTH = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int ROWS_W     = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cfg_load,
  input  logic [4:0]                     cfg_shift,
  input  logic                           cfg_relu,
  input  logic [ROWS_W-1:0]              cfg_rows,
  input  logic [SYS_COLS-1:0]            in_valid,
  input  logic [SYS_COLS*P_BITWIDTH-1:0] in_data,
  output logic                           almost_full,
  output logic                           overflow,
  output_requant_if.master               m
);

  localparam int PX = P_BITWIDTH + 1;            // S1 working width
  localparam int OW = SYS_COLS * O_BITWIDTH;     // packed row width
  localparam int RW = 1 + SYS_COLS + OW;         // stored word {last, strb, data}
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;                    // occupancy needs one extra bit

  localparam logic signed [PX-1:0] SAT_MAX = PX'((2 ** (O_BITWIDTH - 1)) - 1);
  localparam logic signed [PX-1:0] SAT_MIN = PX'(-(2 ** (O_BITWIDTH - 1)));

  // -------------------------------------------------------------------------
  // Latched configuration. A cfg_load in the same cycle as a row event must
  // already apply to that row, so the stages use the "effective" value.
  // -------------------------------------------------------------------------
  logic [4:0]        shift_reg;
  logic              relu_reg;
  logic [ROWS_W-1:0] rows_reg;
  logic [4:0]        eff_shift;
  logic              eff_relu;
  logic [ROWS_W-1:0] eff_rows;

  assign eff_shift = cfg_load ? cfg_shift : shift_reg;
  assign eff_relu  = cfg_load ? cfg_relu  : relu_reg;
  assign eff_rows  = cfg_load ? cfg_rows  : rows_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_reg <= '0;
      relu_reg  <= 1'b0;
      rows_reg  <= ROWS_W'(1);
    end else if (cfg_load) begin
      shift_reg <= cfg_shift;
      relu_reg  <= cfg_relu;
      rows_reg  <= cfg_rows;
    end
  end

  // -------------------------------------------------------------------------
  // S1: round-half-up arithmetic right shift per column.
  // -------------------------------------------------------------------------
  logic                         row_event;
  logic [SYS_COLS-1:0][PX-1:0]  s1_t_next;

  assign row_event = |in_valid;

  generate
    for (genvar gi = 0; gi < SYS_COLS; gi++) begin : g_s1
      logic signed [PX-1:0] x_ext;
      logic signed [PX-1:0] rnd;
      logic signed [PX-1:0] sum;

      // Invalid columns are forced to zero so they saturate to a clean 0.
      assign x_ext = in_valid[gi]
                     ? PX'(signed'(in_data[gi*P_BITWIDTH +: P_BITWIDTH]))
                     : '0;
      // For shift = 0 the rounding constant is unused (selected away below).
      assign rnd   = PX'(1) << (eff_shift - 5'd1);
      assign sum   = x_ext + rnd;
      assign s1_t_next[gi] = (eff_shift == 5'd0) ? x_ext : (sum >>> eff_shift);
    end
  endgenerate

  logic                         s1_valid_reg;
  logic [SYS_COLS-1:0]          s1_strb_reg;
  logic [SYS_COLS-1:0][PX-1:0]  s1_t_reg;
  logic                         s1_relu_reg;
  logic [ROWS_W-1:0]            s1_rows_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_reg <= 1'b0;
      s1_strb_reg  <= '0;
      s1_t_reg     <= '0;
      s1_relu_reg  <= 1'b0;
      s1_rows_reg  <= ROWS_W'(1);
    end else begin
      s1_valid_reg <= row_event;
      s1_strb_reg  <= in_valid;
      s1_t_reg     <= s1_t_next;
      // Remaining config travels with the row it was launched with.
      s1_relu_reg  <= eff_relu;
      s1_rows_reg  <= eff_rows;
    end
  end

  // -------------------------------------------------------------------------
  // S2: ReLU and signed saturation per column.
  // -------------------------------------------------------------------------
  logic [OW-1:0] s2_q_next;

  generate
    for (genvar gi = 0; gi < SYS_COLS; gi++) begin : g_s2
      logic signed [PX-1:0]   t_in;
      logic signed [PX-1:0]   t_act;
      logic [O_BITWIDTH-1:0]  q;

      assign t_in  = s1_t_reg[gi];
      assign t_act = (s1_relu_reg && t_in[PX-1]) ? '0 : t_in;

      always_comb begin
        q = t_act[O_BITWIDTH-1:0];
        if (t_act > SAT_MAX) begin
          q = SAT_MAX[O_BITWIDTH-1:0];
        end else if (t_act < SAT_MIN) begin
          q = SAT_MIN[O_BITWIDTH-1:0];
        end
      end

      assign s2_q_next[gi*O_BITWIDTH +: O_BITWIDTH] = q;
    end
  endgenerate

  logic                s2_valid_reg;
  logic [SYS_COLS-1:0] s2_strb_reg;
  logic [OW-1:0]       s2_q_reg;
  logic [ROWS_W-1:0]   s2_rows_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid_reg <= 1'b0;
      s2_strb_reg  <= '0;
      s2_q_reg     <= '0;
      s2_rows_reg  <= ROWS_W'(1);
    end else begin
      s2_valid_reg <= s1_valid_reg;
      s2_strb_reg  <= s1_strb_reg;
      s2_q_reg     <= s2_q_next;
      s2_rows_reg  <= s1_rows_reg;
    end
  end

  // -------------------------------------------------------------------------
  // Output FIFO. count_reg holds the rows stored in the array, including the
  // one currently presented as head. The head register is a registered read
  // of the array, so a row written at one edge becomes visible one edge later.
  // -------------------------------------------------------------------------
  logic [RW-1:0]     mem [FIFO_DEPTH];
  logic [RW-1:0]     head_reg;
  logic [RW-1:0]     wr_word;
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [AW-1:0]     rd_addr;
  logic [CW-1:0]     count_reg;
  logic [CW-1:0]     count_after_pop;
  logic [CW-1:0]     count_next;
  logic              m_valid_reg;
  logic              almost_full_reg;
  logic              overflow_reg;
  logic              pop;
  logic              full;
  logic              push;
  logic              drop;
  logic [ROWS_W-1:0] row_cnt_reg;
  logic [ROWS_W-1:0] row_cnt_next;
  logic              row_last;

  assign pop  = m_valid_reg & m.m_ready;
  assign full = (count_reg == CW'(FIFO_DEPTH));
  // A pop in the same cycle frees the slot before the write lands.
  assign push = s2_valid_reg & (~full | pop);
  assign drop = s2_valid_reg & full & ~pop;

  assign count_after_pop = count_reg - CW'(pop);
  assign count_next      = count_after_pop + CW'(push);
  assign rd_addr         = rd_ptr_reg + AW'(pop);

  assign row_last = (row_cnt_reg == (s2_rows_reg - ROWS_W'(1)));
  assign wr_word  = {row_last, s2_strb_reg, s2_q_reg};

  // Tile row counter: a write coinciding with cfg_load still uses the old
  // count, and the counter ends at zero either way.
  always_comb begin
    row_cnt_next = row_cnt_reg;
    if (push) begin
      row_cnt_next = row_last ? '0 : row_cnt_reg + ROWS_W'(1);
    end
    if (cfg_load) begin
      row_cnt_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      m_valid_reg     <= 1'b0;
      almost_full_reg <= 1'b0;
      overflow_reg    <= 1'b0;
      row_cnt_reg     <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      rd_ptr_reg      <= rd_addr;
      count_reg       <= count_next;
      // Only rows already in the array can become head at this edge.
      m_valid_reg     <= (count_after_pop != '0);
      almost_full_reg <= (count_next >= CW'(FIFO_DEPTH - 2));
      if (drop) begin
        overflow_reg <= 1'b1;
      end
      row_cnt_reg     <= row_cnt_next;
    end
  end

  // Storage array and registered head read (no reset on the RAM path).
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= wr_word;
    end
    head_reg <= mem[rd_addr];
  end

  assign m.m_valid   = m_valid_reg;
  assign m.m_last    = head_reg[RW-1];
  assign m.m_strb    = head_reg[RW-2 -: SYS_COLS];
  assign m.m_data    = head_reg[OW-1:0];
  assign almost_full = almost_full_reg;
  assign overflow    = overflow_reg;

endmodule

// File: tb/tb_output_requant.sv
// ---------------------------------------------------------------------------
// tb_output_requant
//   Directed scenarios plus randomized traffic for output_requant, checked
//   against a behavioural model: per-row arithmetic requantization, an ideal
//   queue of written rows with capacity FIFO_DEPTH, and a tile row counter.
// ---------------------------------------------------------------------------
module tb_output_requant;
  localparam int COLS  = 4;
  localparam int PW    = 32;
  localparam int OWD   = 8;
  localparam int DEPTH = 8;
  localparam int RWD   = 16;

  logic                 clk;
  logic                 rst;
  logic                 cfg_load;
  logic [4:0]           cfg_shift;
  logic                 cfg_relu;
  logic [RWD-1:0]       cfg_rows;
  logic [COLS-1:0]      in_valid;
  logic [COLS*PW-1:0]   in_data;
  logic                 almost_full;
  logic                 overflow;

  output_requant_if #(.SYS_COLS(COLS), .O_BITWIDTH(OWD)) bus ();

  output_requant #(
    .SYS_COLS(COLS), .P_BITWIDTH(PW), .O_BITWIDTH(OWD),
    .FIFO_DEPTH(DEPTH), .ROWS_W(RWD)
  ) dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_shift(cfg_shift),
    .cfg_relu(cfg_relu), .cfg_rows(cfg_rows), .in_valid(in_valid),
    .in_data(in_data), .almost_full(almost_full), .overflow(overflow),
    .m(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [31:0] data; logic [3:0] strb; logic last; } row_t;
  typedef struct { bit valid; logic [31:0] data; logic [3:0] strb; int rows; } fl_t;

  row_t exp_q[$];
  fl_t  p1, p2;          // rows issued one and two edges ago
  int   mdl_shift, mdl_relu, mdl_rows, mdl_cnt;
  bit   exp_mv, exp_af, exp_ovf;
  bit   last_log[$];

  function automatic logic [31:0] requant(input logic [3:0] v, input logic [127:0] d,
                                          input int sh, input int relu);
    logic [31:0] r;
    logic [31:0] w;
    longint x, t;
    r = '0;
    for (int c = 0; c < COLS; c++) begin
      if (v[c]) begin
        w = d[c*32 +: 32];
        x = longint'(signed'(w));
        if (sh == 0) t = x;
        else t = (x + (longint'(1) <<< (sh - 1))) >>> sh;
        if (relu != 0 && t < 0) t = 0;
        if (t > 127) t = 127;
        if (t < -128) t = -128;
        r[c*8 +: 8] = t[7:0];
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    p1 = '{default: '0};
    p2 = '{default: '0};
    mdl_shift = 0; mdl_relu = 0; mdl_rows = 1; mdl_cnt = 0;
    exp_mv = 0; exp_af = 0; exp_ovf = 0;
  endtask

  // Evaluates one clock edge with the inputs currently applied.
  task automatic model_step();
    fl_t  nw;
    row_t e;
    if (bus.m_valid && bus.m_ready) begin
      chk("sb_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("m_data", bus.m_data, e.data);
        chk("m_strb", bus.m_strb, e.strb);
        chk("m_last", bus.m_last, e.last);
        last_log.push_back(bus.m_last);
      end
    end
    exp_mv = (exp_q.size() != 0);
    if (p2.valid) begin
      if (exp_q.size() == DEPTH) begin
        exp_ovf = 1;
      end else begin
        e.data = p2.data;
        e.strb = p2.strb;
        e.last = (mdl_cnt == p2.rows - 1);
        mdl_cnt = e.last ? 0 : mdl_cnt + 1;
        exp_q.push_back(e);
      end
    end
    exp_af = (exp_q.size() >= DEPTH - 2);
    if (cfg_load) begin
      mdl_shift = cfg_shift; mdl_relu = cfg_relu; mdl_rows = cfg_rows; mdl_cnt = 0;
    end
    nw.valid = |in_valid;
    nw.data  = requant(in_valid, in_data, mdl_shift, mdl_relu);
    nw.strb  = in_valid;
    nw.rows  = mdl_rows;
    p2 = p1;
    p1 = nw;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    chk("m_valid", bus.m_valid, exp_mv);
    chk("almost_full", almost_full, exp_af);
    chk("overflow", overflow, exp_ovf);
  endtask

  task automatic set_idle();
    cfg_load = 0;
    in_valid = '0;
    in_data  = '0;
  endtask

  task automatic set_cfg(input int sh, input int relu, input int rows);
    cfg_load  = 1;
    cfg_shift = 5'(sh);
    cfg_relu  = 1'(relu);
    cfg_rows  = RWD'(rows);
  endtask

  task automatic set_row(input logic [3:0] v, input int c0, input int c1, input int c2, input int c3);
    in_valid = v;
    in_data  = {32'(c3), 32'(c2), 32'(c1), 32'(c0)};
  endtask

  task automatic rand_row();
    int r;
    in_valid = 4'hF;
    for (int c = 0; c < COLS; c++) begin
      r = $urandom_range(0, 600) - 300;
      in_data[c*32 +: 32] = 32'(r);
    end
  endtask

  task automatic do_reset();
    rst = 0;
    #1;
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_almost_full", almost_full, 0);
    chk("rst_overflow", overflow, 0);
    model_reset();
    set_idle();
    @(negedge clk);
    @(negedge clk);
    rst = 1;
  endtask

  task automatic wait_head(input string tag, input logic [31:0] d, input logic [3:0] s, input logic l);
    int k;
    k = 0;
    set_idle();
    while (!bus.m_valid && k < 10) begin
      tick();
      k++;
    end
    chk({tag, "_seen"}, bus.m_valid, 1);
    chk({tag, "_data"}, bus.m_data, d);
    chk({tag, "_strb"}, bus.m_strb, s);
    chk({tag, "_last"}, bus.m_last, l);
  endtask

  task automatic pop_one();
    set_idle();
    bus.m_ready = 1;
    tick();
    bus.m_ready = 0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] held;
    int n, pat, af_idx, r;
    rst = 1;
    bus.m_ready = 0;
    cfg_shift = '0; cfg_relu = 0; cfg_rows = RWD'(1);
    set_idle();
    #2;
    do_reset();

    // Default config, latency of three edges.
    set_row(4'hF, 100, -300, 127, 5);
    tick();
    set_idle();
    tick(); chk("lat_e1", bus.m_valid, 0);
    tick(); chk("lat_e2", bus.m_valid, 0);
    tick(); chk("lat_e3", bus.m_valid, 1);
    wait_head("dflt", 32'h057F8064, 4'hF, 1'b1);
    pop_one();

    // Rounding shift, then with ReLU.
    set_cfg(4, 0, 1); set_row(4'hF, 24, 23, -24, -25); tick();
    wait_head("shift4", 32'hFEFF0102, 4'hF, 1'b1);
    pop_one();
    set_cfg(4, 1, 1); set_row(4'hF, 24, 23, -24, -25); tick();
    wait_head("relu", 32'h00000102, 4'hF, 1'b1);
    pop_one();

    // Partial column mask; empty in_valid writes nothing.
    set_cfg(0, 0, 1); set_row(4'b0101, 50, 50, 50, 50); tick();
    wait_head("mask", 32'h00320032, 4'b0101, 1'b1);
    pop_one();
    for (int i = 0; i < 4; i++) tick();
    chk("idle_no_write", bus.m_valid, 0);

    // Tile of 3 rows, 6 back-to-back rows.
    last_log.delete();
    bus.m_ready = 1;
    for (int i = 0; i < 6; i++) begin
      set_idle();
      if (i == 0) set_cfg(0, 0, 3);
      rand_row();
      tick();
    end
    set_idle();
    for (int i = 0; i < 8; i++) tick();
    pat = 0;
    foreach (last_log[i]) pat |= int'(last_log[i]) << i;
    chk("tile_rows", last_log.size(), 6);
    chk("tile_last_pattern", pat, 6'b100100);

    // cfg_load after the first row restarts the count.
    last_log.delete();
    rand_row(); tick();
    set_idle(); for (int i = 0; i < 3; i++) tick();
    set_cfg(0, 0, 3); tick();
    for (int i = 0; i < 3; i++) begin set_idle(); rand_row(); tick(); end
    set_idle();
    for (int i = 0; i < 8; i++) tick();
    pat = 0;
    foreach (last_log[i]) pat |= int'(last_log[i]) << i;
    chk("restart_rows", last_log.size(), 4);
    chk("restart_last_pattern", pat, 4'b1000);

    // Stall: 10 rows into an 8-deep FIFO.
    bus.m_ready = 0;
    set_cfg(0, 0, 1); tick();
    af_idx = -1;
    for (int k = 0; k < 10; k++) begin
      set_idle(); rand_row(); tick();
      if (af_idx < 0 && almost_full) af_idx = k;
    end
    set_idle();
    for (int i = 0; i < 3; i++) tick();
    chk("af_rise_index", af_idx, 7);
    chk("ovf_set", overflow, 1);
    held = bus.m_data;
    for (int i = 0; i < 3; i++) tick();
    chk("stall_stable", bus.m_data, held);
    bus.m_ready = 1;
    n = 0;
    for (int i = 0; i < 15; i++) begin
      if (bus.m_valid) n++;
      tick();
    end
    chk("drain_count", n, 8);
    chk("ovf_sticky", overflow, 1);

    // Reset with rows buffered.
    bus.m_ready = 0;
    for (int i = 0; i < 5; i++) begin set_idle(); rand_row(); tick(); end
    set_idle();
    for (int i = 0; i < 3; i++) tick();
    chk("pre_rst_valid", bus.m_valid, 1);
    do_reset();
    bus.m_ready = 1;
    set_row(4'hF, 1, 2, 3, 4); tick();
    set_idle();
    tick(); chk("rst_lat_e1", bus.m_valid, 0);
    tick(); chk("rst_lat_e2", bus.m_valid, 0);
    tick(); chk("rst_lat_e3", bus.m_valid, 1);
    chk("rst_first_data", bus.m_data, 32'h04030201);
    tick();

    // Randomized traffic; rows are only issued while almost_full is low.
    for (int i = 0; i < 600; i++) begin
      set_idle();
      bus.m_ready = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 19) == 0)
        set_cfg($urandom_range(0, 31), $urandom_range(0, 1), $urandom_range(1, 4));
      if (!exp_af && $urandom_range(0, 9) < 7) begin
        in_valid = 4'($urandom_range(0, 15));
        for (int c = 0; c < COLS; c++) begin
          case ($urandom_range(0, 3))
            0: in_data[c*32 +: 32] = $urandom;
            1: begin r = $urandom_range(0, 600) - 300; in_data[c*32 +: 32] = 32'(r); end
            2: in_data[c*32 +: 32] = ($urandom_range(0, 1) != 0) ? 32'h7FFFFFFF : 32'h80000000;
            default: begin r = $urandom_range(0, 8191) - 4096; in_data[c*32 +: 32] = 32'(r); end
          endcase
        end
      end
      tick();
    end

    // Drain.
    set_idle();
    bus.m_ready = 1;
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0 && !p1.valid && !p2.valid && !bus.m_valid) break;
      tick();
    end
    chk("final_empty", exp_q.size(), 0);
    chk("final_m_valid", bus.m_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
